// File: rtl/usb_trace_arbiter.sv
// rtl/usb_trace_arbiter.sv - round-robin trace packet arbiter and FX2 EP6 slave FIFO serializer
module usb_trace_arbiter #(
    parameter int NUM_SRC    = 3,
    parameter int FLUSH_IDLE = 1024
) (
    input  logic                  mclk,
    input  logic                  reset,
    input  logic [NUM_SRC-1:0]    src_valid,
    input  logic [24*NUM_SRC-1:0] src_pkt,
    output logic [NUM_SRC-1:0]    src_ack,
    input  logic                  usb_flagb,
    output logic                  usb_ifclk,
    output logic [7:0]            usb_d,
    output logic                  usb_slwr,
    output logic                  usb_pktend,
    output logic                  busy,
    output logic                  stall
);

    localparam int PW = $clog2(NUM_SRC);
    localparam int CW = $clog2(FLUSH_IDLE);

    typedef enum logic [1:0] {IDLE, SEND, FLUSH} state_t;

    state_t        state;
    logic [PW-1:0] ptr;
    logic [CW-1:0] idle_cnt;
    logic          dirty;
    logic          gap;        // tick right after byte 2: re-arbitration slot, no grant
    logic [1:0]    idx;
    logic [15:0]   pkt_tail;   // bytes 1 and 2 of the packet being sent

    logic          tick;
    logic          usb_full;
    logic          grant_found;
    logic [PW-1:0] grant_idx;
    logic [PW-1:0] cand;
    logic [23:0]   grant_pkt;
    logic [7:0]    send_byte;

    // ticks are the mclk edges that take ifclk from 1 to 0
    assign tick      = usb_ifclk;
    assign usb_full  = ~usb_flagb;
    assign send_byte = (idx == 2'd1) ? pkt_tail[15:8] : pkt_tail[7:0];

    // round-robin search for the first valid source after the pointer
    always_comb begin
        grant_found = 1'b0;
        grant_idx   = '0;
        cand        = '0;
        for (int k = 1; k <= NUM_SRC; k++) begin
            cand = PW'((int'(ptr) + k) % NUM_SRC);
            if (!grant_found && src_valid[cand]) begin
                grant_found = 1'b1;
                grant_idx   = cand;
            end
        end
    end

    // mux out the granted source's packet
    always_comb begin
        grant_pkt = '0;
        for (int i = 0; i < NUM_SRC; i++) begin
            if (grant_idx == PW'(i)) begin
                grant_pkt = src_pkt[24*i +: 24];
            end
        end
    end

    // interface clock, arbitration FSM and registered FIFO-side outputs
    always_ff @(posedge mclk or posedge reset) begin
        if (reset) begin
            state      <= IDLE;
            ptr        <= '0;
            idle_cnt   <= '0;
            dirty      <= 1'b0;
            gap        <= 1'b0;
            idx        <= 2'd0;
            pkt_tail   <= '0;
            usb_ifclk  <= 1'b0;
            usb_d      <= 8'h00;
            usb_slwr   <= 1'b1;
            usb_pktend <= 1'b1;
            src_ack    <= '0;
            busy       <= 1'b0;
            stall      <= 1'b0;
        end else begin
            usb_ifclk <= ~usb_ifclk;
            src_ack   <= '0;
            if (tick) begin
                case (state)
                    IDLE: begin
                        gap <= 1'b0;
                        if (grant_found && !usb_full && !gap) begin
                            src_ack[grant_idx] <= 1'b1;
                            pkt_tail <= grant_pkt[15:0];
                            usb_d    <= grant_pkt[23:16];
                            usb_slwr <= 1'b0;
                            ptr      <= grant_idx;
                            dirty    <= 1'b1;
                            idle_cnt <= '0;
                            idx      <= 2'd1;
                            busy     <= 1'b1;
                            state    <= SEND;
                        end else begin
                            usb_slwr <= 1'b1;
                            busy     <= 1'b0;
                            stall    <= 1'b0;
                            if (dirty) begin
                                if (idle_cnt == CW'(FLUSH_IDLE - 1)) begin
                                    if (!usb_full) begin
                                        usb_pktend <= 1'b0;
                                        state      <= FLUSH;
                                    end
                                end else begin
                                    idle_cnt <= idle_cnt + 1'b1;
                                end
                            end
                        end
                    end
                    SEND: begin
                        // pending byte sits on the bus while full; strobe only when there is room
                        usb_d    <= send_byte;
                        usb_slwr <= usb_full;
                        stall    <= usb_full;
                        busy     <= 1'b1;
                        if (!usb_full) begin
                            if (idx == 2'd2) begin
                                gap   <= 1'b1;
                                state <= IDLE;
                            end else begin
                                idx <= 2'd2;
                            end
                        end
                    end
                    FLUSH: begin
                        usb_pktend <= 1'b1;
                        usb_slwr   <= 1'b1;
                        busy       <= 1'b0;
                        stall      <= 1'b0;
                        dirty      <= 1'b0;
                        idle_cnt   <= '0;
                        state      <= IDLE;
                    end
                    default: state <= IDLE;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_usb_trace_arbiter.sv
// tb/tb_usb_trace_arbiter.sv - self-checking bench for usb_trace_arbiter
module tb_usb_trace_arbiter;

    localparam int NUM_SRC    = 3;
    localparam int FLUSH_IDLE = 4;

    logic        mclk      = 1'b0;
    logic        reset     = 1'b1;
    logic [2:0]  src_valid = 3'b000;
    logic [71:0] src_pkt   = '0;
    logic [2:0]  src_ack;
    logic        usb_flagb = 1'b1;
    logic        usb_ifclk;
    logic [7:0]  usb_d;
    logic        usb_slwr;
    logic        usb_pktend;
    logic        busy;
    logic        stall;

    int checks   = 0;
    int failures = 0;

    logic [7:0] exp_q[$];
    logic [7:0] obs_q[$];
    logic [15:0] rst_vec;
    logic [15:0] rst_exp;

    usb_trace_arbiter #(.NUM_SRC(NUM_SRC), .FLUSH_IDLE(FLUSH_IDLE)) dut (
        .mclk(mclk), .reset(reset), .src_valid(src_valid), .src_pkt(src_pkt),
        .src_ack(src_ack), .usb_flagb(usb_flagb), .usb_ifclk(usb_ifclk),
        .usb_d(usb_d), .usb_slwr(usb_slwr), .usb_pktend(usb_pktend),
        .busy(busy), .stall(stall)
    );

    always #5 mclk = ~mclk;

    // record every byte strobed into the FIFO, sampled mid-cycle after each tick
    always @(negedge mclk) begin
        if (!reset && usb_ifclk === 1'b0 && usb_slwr === 1'b0) obs_q.push_back(usb_d);
    end

    initial begin
        #200000;
        $display("FAIL watchdog simulation did not finish");
        $fatal(1);
    end

    task automatic wait_tick();
        int n = 0;
        @(negedge mclk);
        while (usb_ifclk !== 1'b0 && n < 4) begin
            @(negedge mclk);
            n++;
        end
    endtask

    function automatic logic [23:0] make_pkt(int i, int n);
        logic [7:0] b0, b1, b2;
        b0 = 8'(17 * (i + 1));
        b1 = 8'(64 + 16 * i + n);
        b2 = 8'(165 ^ n);
        return {b0, b1, b2};
    endfunction

    task automatic push_pkt(logic [23:0] p);
        exp_q.push_back(p[23:16]);
        exp_q.push_back(p[15:8]);
        exp_q.push_back(p[7:0]);
    endtask

    task automatic test_reset();
        rst_exp = {1'b0, 8'h00, 1'b1, 1'b1, 3'b000, 1'b0, 1'b0};
        reset = 1'b1;
        repeat (3) @(negedge mclk);
        rst_vec = {usb_ifclk, usb_d, usb_slwr, usb_pktend, src_ack, busy, stall};
        checks++;
        if (rst_vec !== rst_exp) begin
            failures++;
            $display("FAIL reset_outputs got %h want %h", rst_vec, rst_exp);
        end
        reset = 1'b0;
        @(negedge mclk);
        checks++;
        if (usb_ifclk !== 1'b1) begin
            failures++;
            $display("FAIL first_ifclk_high got %b want 1", usb_ifclk);
        end
        @(negedge mclk);
        checks++;
        if (usb_ifclk !== 1'b0) begin
            failures++;
            $display("FAIL first_tick got %b want 0", usb_ifclk);
        end
    endtask

    task automatic test_single();
        logic [4:0] slwr_v, busy_v;
        push_pkt(24'h8ABCDE);
        src_pkt[23:0] = 24'h8ABCDE;
        src_valid[0] = 1'b1;
        for (int k = 0; k < 8; k++) begin
            wait_tick();
            if (src_ack !== 3'b000) break;
        end
        checks++;
        if (src_ack !== 3'b001) begin
            failures++;
            $display("FAIL single_ack got %b want 001", src_ack);
        end
        src_valid[0] = 1'b0;
        slwr_v[0] = usb_slwr;
        busy_v[0] = busy;
        @(negedge mclk);
        checks++;
        if (src_ack !== 3'b000) begin
            failures++;
            $display("FAIL single_ack_width got %b want 000", src_ack);
        end
        for (int k = 1; k < 5; k++) begin
            wait_tick();
            slwr_v[k] = usb_slwr;
            busy_v[k] = busy;
        end
        checks++;
        if (slwr_v !== 5'b11000) begin
            failures++;
            $display("FAIL single_slwr got %b want 11000", slwr_v);
        end
        checks++;
        if (busy_v !== 5'b00111) begin
            failures++;
            $display("FAIL single_busy got %b want 00111", busy_v);
        end
        repeat (8) wait_tick();
        checks++;
        if (obs_q.size() != exp_q.size()) begin
            failures++;
            $display("FAIL single_count got %0d want %0d", obs_q.size(), exp_q.size());
        end
        foreach (exp_q[i]) if (i < obs_q.size()) begin
            checks++;
            if (obs_q[i] !== exp_q[i]) begin
                failures++;
                $display("FAIL single_byte%0d got %h want %h", i, obs_q[i], exp_q[i]);
            end
        end
        obs_q.delete();
        exp_q.delete();
    endtask

    task automatic test_flush();
        int pk_first = -1;
        int pk_count = 0;
        repeat (2) wait_tick();
        push_pkt(24'h445566);
        src_pkt[47:24] = 24'h445566;
        src_valid[1] = 1'b1;
        for (int k = 0; k < 8; k++) begin
            wait_tick();
            if (src_ack !== 3'b000) break;
        end
        checks++;
        if (src_ack !== 3'b010) begin
            failures++;
            $display("FAIL flush_ack got %b want 010", src_ack);
        end
        src_valid[1] = 1'b0;
        for (int k = 1; k <= 14; k++) begin
            wait_tick();
            if (usb_pktend === 1'b0) begin
                pk_count++;
                if (pk_first < 0) pk_first = k;
            end
        end
        checks++;
        if (pk_first != 6) begin
            failures++;
            $display("FAIL flush_delay got %0d ticks after grant want 6", pk_first);
        end
        checks++;
        if (pk_count != 1) begin
            failures++;
            $display("FAIL flush_count got %0d want 1", pk_count);
        end
        repeat (8) wait_tick();
        checks++;
        if (obs_q.size() != exp_q.size()) begin
            failures++;
            $display("FAIL flush_bytes_count got %0d want %0d", obs_q.size(), exp_q.size());
        end
        foreach (exp_q[i]) if (i < obs_q.size()) begin
            checks++;
            if (obs_q[i] !== exp_q[i]) begin
                failures++;
                $display("FAIL flush_byte%0d got %h want %h", i, obs_q[i], exp_q[i]);
            end
        end
        obs_q.delete();
        exp_q.delete();
    endtask

    task automatic test_full_stall();
        repeat (2) wait_tick();
        push_pkt(24'h778899);
        src_pkt[71:48] = 24'h778899;
        src_valid[2] = 1'b1;
        for (int k = 0; k < 8; k++) begin
            wait_tick();
            if (src_ack !== 3'b000) break;
        end
        checks++;
        if (src_ack !== 3'b100) begin
            failures++;
            $display("FAIL stall_ack got %b want 100", src_ack);
        end
        src_valid[2] = 1'b0;
        wait_tick();
        usb_flagb = 1'b0;
        for (int k = 0; k < 5; k++) begin
            wait_tick();
            checks++;
            if ({usb_d, usb_slwr, stall, src_ack} !== {8'h99, 1'b1, 1'b1, 3'b000}) begin
                failures++;
                $display("FAIL stall_hold%0d got d=%h slwr=%b stall=%b ack=%b want d=99 slwr=1 stall=1 ack=000",
                         k, usb_d, usb_slwr, stall, src_ack);
            end
        end
        usb_flagb = 1'b1;
        wait_tick();
        checks++;
        if ({usb_d, usb_slwr, stall, busy} !== {8'h99, 1'b0, 1'b0, 1'b1}) begin
            failures++;
            $display("FAIL stall_release got d=%h slwr=%b stall=%b busy=%b want d=99 slwr=0 stall=0 busy=1",
                     usb_d, usb_slwr, stall, busy);
        end
        repeat (8) wait_tick();
        checks++;
        if (obs_q.size() != exp_q.size()) begin
            failures++;
            $display("FAIL stall_count got %0d want %0d", obs_q.size(), exp_q.size());
        end
        foreach (exp_q[i]) if (i < obs_q.size()) begin
            checks++;
            if (obs_q[i] !== exp_q[i]) begin
                failures++;
                $display("FAIL stall_byte%0d got %h want %h", i, obs_q[i], exp_q[i]);
            end
        end
        obs_q.delete();
        exp_q.delete();
    endtask

    task automatic test_full_idle();
        repeat (2) wait_tick();
        usb_flagb = 1'b0;
        push_pkt(24'h0A0B0C);
        src_pkt[23:0] = 24'h0A0B0C;
        src_valid[0] = 1'b1;
        for (int k = 0; k < 4; k++) begin
            wait_tick();
            checks++;
            if ({src_ack, usb_slwr} !== {3'b000, 1'b1}) begin
                failures++;
                $display("FAIL full_idle_noack%0d got ack=%b slwr=%b want ack=000 slwr=1", k, src_ack, usb_slwr);
            end
        end
        usb_flagb = 1'b1;
        wait_tick();
        checks++;
        if ({src_ack, usb_d, usb_slwr} !== {3'b001, 8'h0A, 1'b0}) begin
            failures++;
            $display("FAIL full_idle_grant got ack=%b d=%h slwr=%b want ack=001 d=0a slwr=0", src_ack, usb_d, usb_slwr);
        end
        src_valid[0] = 1'b0;
        repeat (8) wait_tick();
        checks++;
        if (obs_q.size() != exp_q.size()) begin
            failures++;
            $display("FAIL full_idle_count got %0d want %0d", obs_q.size(), exp_q.size());
        end
        foreach (exp_q[i]) if (i < obs_q.size()) begin
            checks++;
            if (obs_q[i] !== exp_q[i]) begin
                failures++;
                $display("FAIL full_idle_byte%0d got %h want %h", i, obs_q[i], exp_q[i]);
            end
        end
        obs_q.delete();
        exp_q.delete();
    endtask

    task automatic test_round_robin();
        int order[6];
        int rem[3];
        int sent[3];
        int nsent[3];
        int p = 0;
        int n_grants = 0;
        int last_t = 0;
        int a;
        repeat (2) wait_tick();
        for (int i = 0; i < 3; i++) begin
            rem[i] = 2;
            sent[i] = 0;
            nsent[i] = 0;
        end
        for (int n = 0; n < 6; n++) begin
            for (int k = 1; k <= 3; k++) begin
                if (rem[(p + k) % 3] > 0) begin
                    order[n] = (p + k) % 3;
                    break;
                end
            end
            p = order[n];
            rem[p]--;
            push_pkt(make_pkt(p, nsent[p]));
            nsent[p]++;
        end
        for (int i = 0; i < 3; i++) src_pkt[24*i +: 24] = make_pkt(i, 0);
        src_valid = 3'b111;
        for (int t = 0; t < 40 && n_grants < 6; t++) begin
            wait_tick();
            if (src_ack !== 3'b000) begin
                checks++;
                if (src_ack !== (3'b001 << order[n_grants])) begin
                    failures++;
                    $display("FAIL rr_order%0d got %b want source %0d", n_grants, src_ack, order[n_grants]);
                end
                if (n_grants > 0) begin
                    checks++;
                    if (t - last_t != 4) begin
                        failures++;
                        $display("FAIL rr_spacing%0d got %0d ticks want 4", n_grants, t - last_t);
                    end
                end
                last_t = t;
                a = src_ack[0] ? 0 : (src_ack[1] ? 1 : 2);
                sent[a]++;
                if (sent[a] < 2) src_pkt[24*a +: 24] = make_pkt(a, sent[a]);
                else src_valid[a] = 1'b0;
                n_grants++;
            end
        end
        checks++;
        if (n_grants != 6) begin
            failures++;
            $display("FAIL rr_grants got %0d want 6", n_grants);
        end
        src_valid = 3'b000;
        repeat (8) wait_tick();
        checks++;
        if (obs_q.size() != exp_q.size()) begin
            failures++;
            $display("FAIL rr_count got %0d want %0d", obs_q.size(), exp_q.size());
        end
        foreach (exp_q[i]) if (i < obs_q.size()) begin
            checks++;
            if (obs_q[i] !== exp_q[i]) begin
                failures++;
                $display("FAIL rr_byte%0d got %h want %h", i, obs_q[i], exp_q[i]);
            end
        end
        obs_q.delete();
        exp_q.delete();
    endtask

    task automatic test_reset_mid();
        repeat (2) wait_tick();
        src_pkt[47:24] = 24'hC1C2C3;
        src_valid[1] = 1'b1;
        for (int k = 0; k < 8; k++) begin
            wait_tick();
            if (src_ack !== 3'b000) break;
        end
        checks++;
        if (src_ack !== 3'b010) begin
            failures++;
            $display("FAIL mid_ack got %b want 010", src_ack);
        end
        exp_q.push_back(8'hC1);
        exp_q.push_back(8'hC2);
        src_pkt[47:24] = 24'hD1D2D3;
        wait_tick();
        #1 reset = 1'b1;
        #1;
        rst_vec = {usb_ifclk, usb_d, usb_slwr, usb_pktend, src_ack, busy, stall};
        checks++;
        if (rst_vec !== rst_exp) begin
            failures++;
            $display("FAIL mid_reset_outputs got %h want %h", rst_vec, rst_exp);
        end
        repeat (3) @(negedge mclk);
        reset = 1'b0;
        wait_tick();
        checks++;
        if ({src_ack, usb_d, usb_slwr} !== {3'b010, 8'hD1, 1'b0}) begin
            failures++;
            $display("FAIL mid_restart got ack=%b d=%h slwr=%b want ack=010 d=d1 slwr=0", src_ack, usb_d, usb_slwr);
        end
        src_valid[1] = 1'b0;
        push_pkt(24'hD1D2D3);
        repeat (8) wait_tick();
        checks++;
        if (obs_q.size() != exp_q.size()) begin
            failures++;
            $display("FAIL mid_count got %0d want %0d", obs_q.size(), exp_q.size());
        end
        foreach (exp_q[i]) if (i < obs_q.size()) begin
            checks++;
            if (obs_q[i] !== exp_q[i]) begin
                failures++;
                $display("FAIL mid_byte%0d got %h want %h", i, obs_q[i], exp_q[i]);
            end
        end
        obs_q.delete();
        exp_q.delete();
    endtask

    initial begin
        test_reset();
        test_single();
        test_flush();
        test_full_stall();
        test_full_idle();
        test_round_robin();
        test_reset_mid();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
